// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result signal bundle for the signed divider
interface div_unit_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed restoring divider, quotient to lo, remainder to hi
module div_unit (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nx;
  logic [5:0]  count;
  logic [31:0] rem, quo, dsr;
  logic        dvd_neg, sign_diff;
  logic [31:0] hi_r, lo_r;
  logic        done_r, div0_r;

  logic        accept, accept_zero, step, finish;
  logic [31:0] dvd_abs, dsr_abs;
  logic [31:0] rem_sh;
  logic [32:0] trial;

  assign dvd_abs = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
  assign dsr_abs = bus.divisor[31]  ? (~bus.divisor  + 32'd1) : bus.divisor;

  // rem stays below dsr (at most 2^31), so its top bit is always clear before the shift
  assign rem_sh = {rem[30:0], quo[31]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dsr};

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == 32'd0) begin
            accept_zero = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == 6'd31) state_nx = FIX;
      end
      FIX: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= 6'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      dsr       <= 32'd0;
      dvd_neg   <= 1'b0;
      sign_diff <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      done_r    <= 1'b0;
      div0_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        rem       <= 32'd0;
        quo       <= dvd_abs;
        dsr       <= dsr_abs;
        dvd_neg   <= bus.dividend[31];
        sign_diff <= bus.dividend[31] ^ bus.divisor[31];
        count     <= 6'd0;
        div0_r    <= 1'b0;
      end
      if (accept_zero) begin
        div0_r <= 1'b1;
        done_r <= 1'b1;
      end
      if (step) begin
        rem   <= trial[32] ? rem_sh : trial[31:0];
        quo   <= {quo[30:0], ~trial[32]};
        count <= count + 6'd1;
      end
      if (finish) begin
        lo_r   <= sign_diff ? (~quo + 32'd1) : quo;
        hi_r   <= dvd_neg   ? (~rem + 32'd1) : rem;
        done_r <= 1'b1;
      end
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
